io_input_debounce: RTL and testbench

- Upstream conditioning stage for the load/store unit's input buffer.
- Takes raw asynchronous board pushbuttons and switches, synchronises them into i_clk, and debounces the buttons.
- Drives the LSU's i_io_btn / i_io_sw inputs with clean, stable levels.
- Also provides a one-cycle press pulse per button for future interrupt/event use.

---
 rtl/io_input_debounce.sv | 120 ++++++++++++
 tb/tb_io_input_debounce.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_debounce.sv
// Input conditioning for the LSU: synchronises raw keys/switches into i_clk, debounces keys, emits press pulses.
// Build option: define SW_DEBOUNCE_EN to debounce the 32 switches with one shared counter.
module io_input_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500000,
  localparam int CNT_W      = $clog2(DB_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_btn_raw,
  input  logic [31:0] i_sw_raw,
  output logic [3:0]  o_io_btn,
  output logic [31:0] o_io_sw,
  output logic [3:0]  o_btn_press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Synchroniser chains: stage 0 samples the raw pins, the last stage is the clean copy.
  logic [SYNC_STAGES-1:0][3:0]  btn_sync_q;
  logic [SYNC_STAGES-1:0][31:0] sw_sync_q;
  logic [3:0]                   s_btn;
  logic [31:0]                  s_sw;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      btn_sync_q <= '1;
      sw_sync_q  <= '0;
    end else begin
      btn_sync_q[0] <= i_btn_raw;
      sw_sync_q[0]  <= i_sw_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        btn_sync_q[k] <= btn_sync_q[k-1];
        sw_sync_q[k]  <= sw_sync_q[k-1];
      end
    end
  end

  assign s_btn = btn_sync_q[SYNC_STAGES-1];
  assign s_sw  = sw_sync_q[SYNC_STAGES-1];

  // Per-key debounce: the count only advances while the synced level disagrees with the
  // stable level, so any agreement (a glitch ending) drops it back to zero.
  logic [3:0]            btn_q, btn_d;
  logic [3:0]            press_q, press_d;
  logic [3:0][CNT_W-1:0] btn_cnt_q, btn_cnt_d;

  always_comb begin
    btn_d     = btn_q;
    press_d   = '0;
    btn_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (s_btn[i] != btn_q[i]) begin
        if (btn_cnt_q[i] >= CNT_MAX) begin
          btn_d[i]   = s_btn[i];
          press_d[i] = btn_q[i];
        end else begin
          btn_cnt_d[i] = btn_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      btn_q     <= 4'hF;
      press_q   <= 4'h0;
      btn_cnt_q <= '0;
    end else begin
      btn_q     <= btn_d;
      press_q   <= press_d;
      btn_cnt_q <= btn_cnt_d;
    end
  end

  // Switch path: one output register, optionally gated by a shared stability counter.
  logic [31:0] sw_q, sw_d;

`ifdef SW_DEBOUNCE_EN
  logic [31:0]      sw_prev_q;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;

  always_comb begin
    sw_d     = sw_q;
    sw_cnt_d = '0;
    if ((s_sw == sw_prev_q) && (s_sw != sw_q)) begin
      if (sw_cnt_q >= CNT_MAX) begin
        sw_d = s_sw;
      end else begin
        sw_cnt_d = sw_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sw_prev_q <= '0;
      sw_cnt_q  <= '0;
    end else begin
      sw_prev_q <= s_sw;
      sw_cnt_q  <= sw_cnt_d;
    end
  end
`else
  assign sw_d = s_sw;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sw_q <= '0;
    end else begin
      sw_q <= sw_d;
    end
  end

  assign o_io_btn    = btn_q;
  assign o_btn_press = press_q;
  assign o_io_sw     = sw_q;

endmodule

// File: tb/tb_io_input_debounce.sv
// Bench for io_input_debounce (SYNC_STAGES=2, DB_CYCLES=4): directed latency scenarios plus a
// randomized run against a history-based reference model.
module tb_io_input_debounce;

  localparam int SYNC = 2;
  localparam int DB   = 4;
`ifdef SW_DEBOUNCE_EN
  localparam int SW_LAT = SYNC + DB + 1;
`else
  localparam int SW_LAT = SYNC + 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  btn_raw;
  logic [31:0] sw_raw;
  logic [3:0]  o_io_btn;
  logic [31:0] o_io_sw;
  logic [3:0]  o_btn_press;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_input_debounce #(
    .SYNC_STAGES(SYNC),
    .DB_CYCLES  (DB)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_btn_raw  (btn_raw),
    .i_sw_raw   (sw_raw),
    .o_io_btn   (o_io_btn),
    .o_io_sw    (o_io_sw),
    .o_btn_press(o_btn_press)
  );

  // Reference model: raw samples delayed SYNC edges; a key flips once its last DB synced
  // samples all disagree with it; switches follow the rule on the last DB+1 synced samples.
  logic [3:0]  exp_btn   = 4'hF;
  logic [3:0]  exp_press = 4'h0;
  logic [31:0] exp_sw    = 32'h0;
  logic [3:0]  m_braw[$];
  logic [31:0] m_sraw[$];
  logic [3:0]  m_bhist[$];
  logic [31:0] m_shist[$];

  always @(posedge clk) begin : model
    logic [3:0]  b_s, nb, np;
    logic [31:0] s_s;
    int          diff;
    logic        same;
    if (!rst_n) begin
      m_braw.delete(); m_sraw.delete(); m_bhist.delete(); m_shist.delete();
      for (int i = 0; i < SYNC; i++) begin
        m_braw.push_back(4'hF);
        m_sraw.push_back(32'h0);
      end
      m_shist.push_back(32'h0);
      exp_btn = 4'hF; exp_press = 4'h0; exp_sw = 32'h0;
    end else begin
      b_s = m_braw[SYNC-1];
      s_s = m_sraw[SYNC-1];
      m_braw.push_front(btn_raw); void'(m_braw.pop_back());
      m_sraw.push_front(sw_raw);  void'(m_sraw.pop_back());
      m_bhist.push_back(b_s);
      if (m_bhist.size() > DB) void'(m_bhist.pop_front());
      nb = exp_btn; np = 4'h0;
      for (int b = 0; b < 4; b++) begin
        diff = 0;
        foreach (m_bhist[k]) if (m_bhist[k][b] != exp_btn[b]) diff++;
        if (diff == DB) begin
          nb[b] = ~exp_btn[b];
          np[b] = exp_btn[b];
        end
      end
      exp_btn = nb; exp_press = np;
      m_shist.push_back(s_s);
      if (m_shist.size() > DB + 1) void'(m_shist.pop_front());
`ifdef SW_DEBOUNCE_EN
      same = (m_shist.size() == DB + 1);
      foreach (m_shist[k]) if (m_shist[k] != s_s) same = 1'b0;
      if (same && (s_s != exp_sw)) exp_sw = s_s;
`else
      same = 1'b0;
      exp_sw = s_s;
`endif
    end
  end

  // Advance one rising edge and land on the following falling edge.
  task automatic next_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) next_edge();
  endtask

  task automatic test_reset();
    logic [3:0]  eb, ep;
    logic [31:0] es;
    rst_n = 1'b0; btn_raw = 4'h0; sw_raw = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      next_edge();
      checks++; if (o_io_btn !== 4'hF) begin errors++; $display("FAIL reset_btn cyc=%0d got=%h exp=F", i, o_io_btn); end
      checks++; if (o_io_sw !== 32'h0) begin errors++; $display("FAIL reset_sw cyc=%0d got=%h exp=0", i, o_io_sw); end
      checks++; if (o_btn_press !== 4'h0) begin errors++; $display("FAIL reset_press cyc=%0d got=%h exp=0", i, o_btn_press); end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      eb = (k >= SYNC + DB) ? 4'h0 : 4'hF;
      ep = (k == SYNC + DB) ? 4'hF : 4'h0;
      es = (k >= SW_LAT) ? 32'hFFFF_FFFF : 32'h0;
      checks++; if (o_io_btn !== eb) begin errors++; $display("FAIL post_reset_btn edge=%0d got=%h exp=%h", k, o_io_btn, eb); end
      checks++; if (o_btn_press !== ep) begin errors++; $display("FAIL post_reset_press edge=%0d got=%h exp=%h", k, o_btn_press, ep); end
      checks++; if (o_io_sw !== es) begin errors++; $display("FAIL post_reset_sw edge=%0d got=%h exp=%h", k, o_io_sw, es); end
    end
  endtask

  task automatic test_clean_press();
    btn_raw = 4'hF; sw_raw = 32'h0;
    settle(12);
    btn_raw = 4'hE;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      checks++; if (o_io_btn[0] !== ((k >= 6) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL press_level edge=%0d got=%b", k, o_io_btn[0]); end
      checks++; if (o_btn_press !== ((k == 6) ? 4'h1 : 4'h0)) begin errors++; $display("FAIL press_pulse edge=%0d got=%h exp=%h", k, o_btn_press, (k == 6) ? 4'h1 : 4'h0); end
    end
    btn_raw = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      checks++; if (o_io_btn[0] !== ((k >= 6) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL release_level edge=%0d got=%b", k, o_io_btn[0]); end
      checks++; if (o_btn_press !== 4'h0) begin errors++; $display("FAIL release_pulse edge=%0d got=%h exp=0", k, o_btn_press); end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    btn_raw = 4'hF;
    settle(4);
    for (int k = 1; k <= 16; k++) begin
      btn_raw[1] = (k >= 4 && k <= 6) ? 1'b1 : 1'b0;
      next_edge();
      if (o_btn_press[1]) pulses++;
      checks++; if (o_io_btn[1] !== ((k >= 12) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL bounce_level edge=%0d got=%b", k, o_io_btn[1]); end
      checks++; if (o_btn_press[1] !== (k == 12)) begin errors++; $display("FAIL bounce_pulse edge=%0d got=%b", k, o_btn_press[1]); end
      checks++; if (o_io_btn !== exp_btn) begin errors++; $display("FAIL bounce_model edge=%0d got=%h exp=%h", k, o_io_btn, exp_btn); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_pulse_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_simultaneous();
    btn_raw = 4'hF;
    settle(10);
    btn_raw = 4'h5;
    for (int k = 1; k <= 7; k++) begin
      next_edge();
      checks++; if (o_io_btn !== ((k >= 6) ? 4'h5 : 4'hF)) begin errors++; $display("FAIL simul_level edge=%0d got=%h", k, o_io_btn); end
      checks++; if (o_btn_press !== ((k == 6) ? 4'hA : 4'h0)) begin errors++; $display("FAIL simul_pulse edge=%0d got=%h", k, o_btn_press); end
    end
  endtask

  task automatic test_reset_mid();
    btn_raw = 4'hF;
    settle(10);
    btn_raw = 4'hB;
    settle(4);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_edge();
      checks++; if (o_io_btn !== 4'hF) begin errors++; $display("FAIL midrst_btn cyc=%0d got=%h exp=F", i, o_io_btn); end
      checks++; if (o_btn_press !== 4'h0) begin errors++; $display("FAIL midrst_press cyc=%0d got=%h exp=0", i, o_btn_press); end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      next_edge();
      checks++; if (o_io_btn !== ((k >= 6) ? 4'hB : 4'hF)) begin errors++; $display("FAIL midrst_level edge=%0d got=%h", k, o_io_btn); end
      checks++; if (o_btn_press !== ((k == 6) ? 4'h4 : 4'h0)) begin errors++; $display("FAIL midrst_pulse edge=%0d got=%h", k, o_btn_press); end
    end
  endtask

  task automatic test_sw();
    logic [31:0] es;
    btn_raw = 4'hF; sw_raw = 32'h0;
    settle(12);
    for (int k = 1; k <= 14; k++) begin
      sw_raw = (k == 4 || k == 5) ? 32'h0000_00A4 : 32'h0000_00A5;
      next_edge();
`ifdef SW_DEBOUNCE_EN
      es = (k >= 12) ? 32'h0000_00A5 : 32'h0;
`else
      es = (k < 3) ? 32'h0 : (k == 6 || k == 7) ? 32'h0000_00A4 : 32'h0000_00A5;
`endif
      checks++; if (o_io_sw !== es) begin errors++; $display("FAIL sw_level edge=%0d got=%h exp=%h", k, o_io_sw, es); end
      checks++; if (o_io_sw !== exp_sw) begin errors++; $display("FAIL sw_model edge=%0d got=%h exp=%h", k, o_io_sw, exp_sw); end
    end
  endtask

  task automatic test_random();
    int hold[4];
    int sw_hold = 0;
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          btn_raw[b] = 1'($urandom_range(0, 1));
          hold[b]    = $urandom_range(1, 7);
        end else begin
          hold[b]--;
        end
      end
      if (sw_hold == 0) begin
        sw_raw[$urandom_range(0, 7)] ^= 1'b1;
        if ($urandom_range(0, 9) == 0) sw_raw = $urandom();
        sw_hold = $urandom_range(0, 8);
      end else begin
        sw_hold--;
      end
      rst_n = ($urandom_range(0, 149) != 0);
      next_edge();
      checks++; if (o_io_btn !== exp_btn) begin errors++; $display("FAIL rand_btn cyc=%0d got=%h exp=%h", c, o_io_btn, exp_btn); end
      checks++; if (o_btn_press !== exp_press) begin errors++; $display("FAIL rand_press cyc=%0d got=%h exp=%h", c, o_btn_press, exp_press); end
      checks++; if (o_io_sw !== exp_sw) begin errors++; $display("FAIL rand_sw cyc=%0d got=%h exp=%h", c, o_io_sw, exp_sw); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; btn_raw = 4'h0; sw_raw = 32'hFFFF_FFFF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_sw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
